// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan for a 4-digit common-anode
// seven-segment display. One shared hex decoder is fed one nibble per digit
// slot. New values are double-buffered and committed only at frame boundaries.
// Optional feature: define LEADING_ZERO_BLANK_EN to auto-blank leading zero
// digits (digits 3..1; digit 0 is always shown unless masked by blank_i).
module seg_scan_controller #(
  parameter int unsigned CLK_DIV = 100000  // clock cycles per digit slot, 2..2^20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic [3:0]  blank_i,
  input  logic        load_i,
  output logic [3:0]  nibble_o,
  output logic [3:0]  an_o,
  output logic        upd_ack_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  // Handshake: load_i is a one-cycle strobe sampled on every rising edge with
  // no back-pressure; upd_ack_o is a one-cycle pulse, registered, high in the
  // cycle after the edge on which the shadow register took a new value.

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shd_val_q, shd_val_d;
  logic [3:0]       shd_blk_q, shd_blk_d;
  logic [15:0]      pnd_val_q, pnd_val_d;
  logic [3:0]       pnd_blk_q, pnd_blk_d;
  logic             pend_q, pend_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             ack_q, ack_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       auto_blk;
  logic [3:0]       eff_blk;
  logic [3:0]       onehot;

  // Prescaler, digit index and double-buffer commit decisions.
  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    boundary  = tick && (idx_q == 2'd3);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    shd_val_d = shd_val_q;
    shd_blk_d = shd_blk_q;
    pnd_val_d = pnd_val_q;
    pnd_blk_d = pnd_blk_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;

    if (boundary && load_i) begin
      // A load coinciding with the frame boundary skips the pending buffer.
      shd_val_d = value_i;
      shd_blk_d = blank_i;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end else if (boundary && pend_q) begin
      shd_val_d = pnd_val_q;
      shd_blk_d = pnd_blk_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end else if (load_i) begin
      // Last load before the boundary wins.
      pnd_val_d = value_i;
      pnd_blk_d = blank_i;
      pend_d    = 1'b1;
    end
  end

  // Blank mask applied to the next-state shadow value, optionally including
  // leading-zero suppression.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    auto_blk[3] = (shd_val_d[15:12] == 4'h0);
    auto_blk[2] = auto_blk[3] && (shd_val_d[11:8] == 4'h0);
    auto_blk[1] = auto_blk[2] && (shd_val_d[7:4] == 4'h0);
    auto_blk[0] = 1'b0;
`else
    auto_blk = 4'b0000;
`endif
    eff_blk = shd_blk_d | auto_blk;
  end

  // Output decode from next-state idx and shadow so the registered anode and
  // nibble always switch together with the index.
  always_comb begin
    onehot   = 4'b0001 << idx_d;
    nibble_d = shd_val_d[{idx_d, 2'b00} +: 4];
    an_d     = eff_blk[idx_d] ? 4'b1111 : ~onehot;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shd_val_q <= 16'h0000;
      shd_blk_q <= 4'b0000;
      pnd_val_q <= 16'h0000;
      pnd_blk_q <= 4'b0000;
      pend_q    <= 1'b0;
      an_q      <= 4'b1111;
      nibble_q  <= 4'h0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_val_q <= shd_val_d;
      shd_blk_q <= shd_blk_d;
      pnd_val_q <= pnd_val_d;
      pnd_blk_q <= pnd_blk_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      nibble_q  <= nibble_d;
      ack_q     <= ack_d;
    end
  end

  assign nibble_o  = nibble_q;
  assign an_o      = an_q;
  assign upd_ack_o = ack_q;

endmodule
